// File: rtl/mnist_pkg.sv
// mnist_pkg: shared loader state encoding, frame header value and pixel-to-word conversion
package mnist_pkg;
    typedef enum logic [1:0] {IDLE, PIX, CHK, COMMIT} loader_state_t;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    function automatic logic [31:0] pix_to_word(input logic [7:0] b, input int unsigned shift);
        return {24'd0, b} << shift;
    endfunction
endpackage

// File: rtl/frame_byte_counter.sv
// frame_byte_counter: payload index, inter-byte idle timer and running XOR checksum
module frame_byte_counter #(
    parameter int ARRAY_A_L = 784,
    parameter int TIMEOUT   = 1024,
    localparam int IW = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1,
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          advance_i,
    input  logic          tick_i,
    input  logic [7:0]    byte_i,
    output logic [IW-1:0] idx_o,
    output logic [7:0]    csum_o,
    output logic          last_o,
    output logic          expired_o
);
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    csum_q, csum_d;
    always_comb begin
        idx_d   = clear_i ? '0 : advance_i ? idx_q + IW'(1) : idx_q;
        csum_d  = clear_i ? '0 : advance_i ? csum_q ^ byte_i : csum_q;
        timer_d = (clear_i || advance_i) ? '0 : tick_i ? timer_q + TW'(1) : timer_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            csum_q  <= '0;
            timer_q <= '0;
        end else begin
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            timer_q <= timer_d;
        end
    end
    assign idx_o     = idx_q;
    assign csum_o    = csum_q;
    assign last_o    = idx_q == IW'(ARRAY_A_L - 1);
    assign expired_o = timer_q == TW'(TIMEOUT - 1);
endmodule

// File: rtl/mnist_image_loader.sv
// mnist_image_loader: assembles a framed, checksummed byte stream into a stable pixel vector
module mnist_image_loader
    import mnist_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         ARRAY_A_L  = 784,
    parameter int         PIX_SHIFT  = 0,
    parameter logic [7:0] HEADER     = HEADER_BYTE,
    parameter int         TIMEOUT    = 1024,
    localparam int IW = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  comp_busy,
    output logic [DATA_WIDTH-1:0] image_out [0:ARRAY_A_L-1],
    output logic                  image_valid,
    output logic                  image_start,
    output logic                  frame_err,
    output logic [7:0]            err_count
);
    loader_state_t         state_q;
    logic                  rx_ready_q, image_valid_q, image_start_q, frame_err_q;
    logic [7:0]            err_count_q;
    logic [7:0]            cap_buf [ARRAY_A_L];
    logic [DATA_WIDTH-1:0] image_out_q [0:ARRAY_A_L-1];
    logic [IW-1:0]         idx;
    logic [7:0]            csum;
    logic                  last, expired;
    logic                  acc, hdr_hit, pix_acc, pix_idle, timeout, chk_ok, chk_bad, commit, err_hit;
    always_comb begin
        acc      = rx_valid && rx_ready_q;
        hdr_hit  = state_q == IDLE && acc && rx_data == HEADER;
        pix_acc  = state_q == PIX && acc;
        pix_idle = state_q == PIX && !acc;
        timeout  = pix_idle && expired;
        chk_ok   = state_q == CHK && acc && rx_data == csum;
        chk_bad  = state_q == CHK && acc && rx_data != csum;
        commit   = state_q == COMMIT && !comp_busy;
        err_hit  = timeout || chk_bad;
    end
    frame_byte_counter #(.ARRAY_A_L(ARRAY_A_L), .TIMEOUT(TIMEOUT)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (hdr_hit),
        .advance_i (pix_acc),
        .tick_i    (pix_idle),
        .byte_i    (rx_data),
        .idx_o     (idx),
        .csum_o    (csum),
        .last_o    (last),
        .expired_o (expired)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rx_ready_q    <= 1'b1;
            image_valid_q <= 1'b0;
            image_start_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            image_start_q <= commit;
            frame_err_q   <= err_hit;
            if (err_hit && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
            if (chk_ok)
                rx_ready_q <= 1'b0;
            if (commit) begin
                rx_ready_q    <= 1'b1;
                image_valid_q <= 1'b1;
            end
            case (state_q)
                IDLE:    if (hdr_hit) state_q <= PIX;
                PIX:     if (pix_acc && last) state_q <= CHK; else if (timeout) state_q <= IDLE;
                CHK:     if (acc) state_q <= chk_ok ? COMMIT : IDLE;
                COMMIT:  if (!comp_busy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    // capture buffer is deliberately unreset; only a checksummed frame ever reaches image_out
    always_ff @(posedge clk) begin
        if (pix_acc)
            cap_buf[idx] <= rx_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARRAY_A_L; i++)
                image_out_q[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < ARRAY_A_L; i++)
                image_out_q[i] <= DATA_WIDTH'(pix_to_word(cap_buf[i], PIX_SHIFT));
        end
    end
    assign image_out   = image_out_q;
    assign rx_ready    = rx_ready_q;
    assign image_valid = image_valid_q;
    assign image_start = image_start_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_mnist_image_loader.sv
// tb_mnist_image_loader: randomized frame stream with scoreboard of expected commit/error events
module tb_mnist_image_loader;
    localparam int DW = 16, N = 64, SH = 2, TO = 48;
    typedef logic [N-1:0][7:0] img_t;
    typedef struct packed { logic err; int cyc; int errc; img_t img; } item_t;
    logic          clk = 0, reset = 1, rx_valid = 0, comp_busy = 0;
    logic [7:0]    rx_data = 0;
    logic          rx_ready, image_valid, image_start, frame_err;
    logic [7:0]    err_count;
    logic [DW-1:0] image_out [0:N-1];
    int            cyc = 0, checks = 0, errors = 0, model_errs = 0, mon_bad;
    img_t          model_img = '0;
    item_t         sb[$];
    item_t         mon_it;

    mnist_image_loader #(.DATA_WIDTH(DW), .ARRAY_A_L(N), .PIX_SHIFT(SH), .HEADER(8'hA5), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .comp_busy(comp_busy), .image_out(image_out), .image_valid(image_valid),
        .image_start(image_start), .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int x);
        return x > 255 ? 255 : x;
    endfunction
    function automatic int img_diff(input img_t img);
        int n = 0;
        for (int i = 0; i < N; i++)
            if (int'(image_out[i]) != int'(img[i]) * (1 << SH)) n++;
        return n;
    endfunction
    function automatic img_t rand_img(input bit hdr);
        img_t r;
        for (int i = 0; i < N; i++) r[i] = 8'($urandom);
        if (hdr) begin
            r[0] = 8'hA5; r[7] = 8'hA5; r[N-1] = 8'hA5;
        end
        return r;
    endfunction
    task automatic check_eq(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (image_start || frame_err)) begin
            check_eq("start_err_exclusive", int'(image_start && frame_err), 0);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: start=%0d err=%0d with no frame pending (cycle %0d)", image_start, frame_err, cyc);
            end else begin
                mon_it = sb.pop_front();
                check_eq("event_is_err", frame_err, mon_it.err);
                check_eq("event_cycle", cyc, mon_it.cyc);
                check_eq("err_count", err_count, mon_it.errc);
                if (!mon_it.err) check_eq("image_valid", image_valid, 1);
                mon_bad = img_diff(mon_it.img);
                check_eq("image_out_bad_words", mon_bad, 0);
            end
        end
    end

    task automatic idle(input int n);
        rx_valid = 0;
        repeat (n) @(negedge clk);
    endtask
    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        rx_data  = b;
        rx_valid = 1;
        for (int t = 0; t < 1000 && !got; t++) begin
            got = rx_ready;
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL rx_ready_wait: got rx_ready=0 for 1000 cycles, expected 1");
        end
        rx_valid = 0;
        rx_data  = 8'($urandom);
    endtask
    task automatic push(input logic e, input int c, input img_t img);
        sb.push_back('{e, c, sat(model_errs), img});
    endtask
    task automatic send_frame(input img_t img, input bit bad, input int hold, input int maxg);
        logic [7:0] ck = 0;
        int z = 0;
        for (int i = 0; i < N; i++) ck ^= img[i];
        send_byte(8'hA5);
        for (int i = 0; i < N; i++) begin
            idle($urandom_range(maxg, 0));
            send_byte(img[i]);
        end
        comp_busy = hold > 0;
        // checksum is always taken in CHK, so acceptance lands on the very next edge
        if (bad) begin
            model_errs++;
            push(1, cyc + 1, model_img);
        end else begin
            model_img = img;
            push(0, cyc + 2 + hold, img);
        end
        send_byte(bad ? ck ^ 8'h01 : ck);
        if (hold > 0) begin
            repeat (hold) begin
                z += int'(!rx_ready);
                @(negedge clk);
            end
            comp_busy = 0;
            check_eq("busy_rx_ready_low_cycles", z, hold);
        end
    endtask
    task automatic send_trunc(input int k);
        idle(3);
        model_errs++;
        if (k == 0) push(1, cyc + 1 + TO, model_img);
        send_byte(8'hA5);
        for (int i = 0; i < k; i++) begin
            if (i == k - 1) push(1, cyc + 1 + TO, model_img);
            send_byte(8'($urandom));
        end
        idle(TO + 4);
    endtask
    task automatic check_reset_outputs();
        int nz = 0;
        for (int i = 0; i < N; i++) if (image_out[i] != 0) nz++;
        check_eq("rst_rx_ready", rx_ready, 1);
        check_eq("rst_image_valid", image_valid, 0);
        check_eq("rst_image_start", image_start, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_image_out_nonzero", nz, 0);
    endtask

    initial begin
        img_t img;
        logic [7:0] garbage [3] = '{8'h00, 8'hFF, 8'h13};
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 0;
        for (int i = 0; i < N; i++) img[i] = 8'((i + 240) % 256);
        send_frame(img, 0, 0, 0);
        idle(3);
        check_eq("word50_after_commit", image_out[50], 136);
        check_eq("valid_after_commit", image_valid, 1);
        send_frame(img, 1, 0, 0);
        idle(3);
        check_eq("err_count_after_bad_ck", err_count, 1);
        check_eq("word50_kept_after_err", image_out[50], 136);
        send_trunc(10);
        send_frame(rand_img(0), 0, 0, 2);
        send_frame(rand_img(0), 0, 50, 1);
        for (int i = 0; i < 3; i++) send_byte(garbage[i]);
        send_frame(rand_img(1), 0, 0, 1);
        for (int f = 0; f < 12; f++) begin
            bit bad = $urandom_range(3, 0) == 0;
            int hold = ($urandom_range(2, 0) == 0) ? int'($urandom_range(20, 1)) : 0;
            send_frame(rand_img(1), bad, bad ? 0 : hold, $urandom_range(3, 0));
            if ($urandom_range(4, 0) == 0) send_trunc($urandom_range(N - 1, 0));
        end
        idle(3);
        send_byte(8'hA5);
        for (int i = 0; i < 30; i++) send_byte(8'($urandom));
        reset = 1;
        idle(3);
        check_reset_outputs();
        check_eq("queue_empty_at_reset", sb.size(), 0);
        model_img  = '0;
        model_errs = 0;
        reset = 0;
        send_frame(rand_img(1), 0, 0, 1);
        for (int f = 0; f < 300; f++) send_frame(rand_img(0), 1, 0, 0);
        idle(4);
        check_eq("err_count_saturated", err_count, 255);
        send_frame(rand_img(0), 0, 0, 0);
        idle(6);
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
